// File: rtl/i2c_command_master.sv
// Write-only I2C master: on start it sends START, {SLAVE_ADDR,W}, six command
// bytes MSB first with ACK checking, then STOP. Bus lines are open-drain.
module i2c_command_master #(
  parameter int unsigned DIVIDER    = 125,
  parameter logic [6:0]  SLAVE_ADDR = 7'h2A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] command,
  output logic        busy,
  output logic        done,
  output logic        nack,
  inout  wire         scl,
  inout  wire         sda
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_BIT   = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam logic [9:0] QLAST = 10'(DIVIDER - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [9:0]  qcnt_q, qcnt_d;
  logic [2:0]  byte_q, byte_d;
  logic [2:0]  bit_q, bit_d;
  logic [47:0] cmd_q, cmd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic        scl_low_q, scl_low_d;
  logic        sda_low_q, sda_low_d;

  logic        hold;
  logic        tick;
  logic [7:0]  tx_byte_d;
  logic        tx_bit_d;

  function automatic logic [7:0] byte_sel(input logic [2:0] idx, input logic [47:0] cmd);
    case (idx)
      3'd0:    byte_sel = {SLAVE_ADDR, 1'b0};
      3'd1:    byte_sel = cmd[47:40];
      3'd2:    byte_sel = cmd[39:32];
      3'd3:    byte_sel = cmd[31:24];
      3'd4:    byte_sel = cmd[23:16];
      3'd5:    byte_sel = cmd[15:8];
      3'd6:    byte_sel = cmd[7:0];
      default: byte_sel = '0;
    endcase
  endfunction

  // Returns {scl_low, sda_low} for a given state/quarter; SDA only moves while SCL is low
  // except for the START and STOP edges.
  function automatic logic [1:0] drive(input logic [2:0] st, input logic [1:0] ph,
                                       input logic txb);
    case (st)
      ST_START: drive = {1'b0, ph[1]};
      ST_BIT:   drive = {(ph == 2'd0) || (ph == 2'd3), ~txb};
      ST_ACK:   drive = {(ph == 2'd0) || (ph == 2'd3), 1'b0};
      ST_STOP:  drive = {ph == 2'd0, ~ph[1]};
      default:  drive = 2'b00;
    endcase
  endfunction

  always_comb begin
    hold = busy_q && (phase_q == 2'd2) && (scl == 1'b0);
    tick = busy_q && !hold && (qcnt_q == QLAST);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    qcnt_d  = qcnt_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    cmd_d   = cmd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    nack_d  = nack_q;

    if (!busy_q) begin
      if (start) begin
        state_d = ST_START;
        phase_d = '0;
        qcnt_d  = '0;
        byte_d  = '0;
        bit_d   = 3'd7;
        cmd_d   = command;
        busy_d  = 1'b1;
        nack_d  = 1'b0;
      end
    end else begin
      if (!hold) begin
        qcnt_d = tick ? '0 : qcnt_q + 10'd1;
      end
      if (tick) begin
        phase_d = phase_q + 2'd1;
        if ((state_q == ST_ACK) && (phase_q == 2'd2) && (sda == 1'b1)) begin
          nack_d = 1'b1;
        end
        if (phase_q == 2'd3) begin
          case (state_q)
            ST_START: begin
              state_d = ST_BIT;
              byte_d  = '0;
              bit_d   = 3'd7;
            end
            ST_BIT: begin
              if (bit_q == 3'd0) begin
                state_d = ST_ACK;
              end else begin
                bit_d = bit_q - 3'd1;
              end
            end
            ST_ACK: begin
              if (nack_q || (byte_q == 3'd6)) begin
                state_d = ST_STOP;
              end else begin
                state_d = ST_BIT;
                byte_d  = byte_q + 3'd1;
                bit_d   = 3'd7;
              end
            end
            ST_STOP: begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              byte_d  = '0;
              bit_d   = '0;
            end
            default: begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          endcase
        end
      end
    end

    // Line drives are registered from the next state so the pins never glitch.
    tx_byte_d              = byte_sel(byte_d, cmd_d);
    tx_bit_d               = tx_byte_d[bit_d];
    {scl_low_d, sda_low_d} = drive(state_d, phase_d, tx_bit_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      qcnt_q    <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      cmd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      qcnt_q    <= qcnt_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      cmd_q     <= cmd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign scl  = scl_low_q ? 1'b0 : 1'bz;
  assign sda  = sda_low_q ? 1'b0 : 1'bz;
  assign busy = busy_q;
  assign done = done_q;
  assign nack = nack_q;

endmodule

// File: tb/tb_i2c_command_master.sv
// Directed bench for i2c_command_master with a bus monitor / ACKing slave model.
module tb_i2c_command_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [47:0] command;
  logic        busy;
  logic        done;
  logic        nack;
  wire         scl;
  wire         sda;

  logic        slv_scl_low = 1'b0;
  logic        slv_sda_low = 1'b0;
  int          nack_at = -1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pullup (scl);
  pullup (sda);
  assign scl = slv_scl_low ? 1'b0 : 1'bz;
  assign sda = slv_sda_low ? 1'b0 : 1'bz;

  i2c_command_master #(.DIVIDER(4), .SLAVE_ADDR(7'h2A)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .command(command),
    .busy   (busy),
    .done   (done),
    .nack   (nack),
    .scl    (scl),
    .sda    (sda)
  );

  always #5 clk = ~clk;

  // Bus monitor and slave: collects bytes, counts START/STOP, ACKs unless told otherwise.
  logic [7:0]  rx[$];
  int unsigned starts = 0;
  int unsigned stops = 0;
  int unsigned bitcnt = 0;
  int          byte_idx = 0;
  logic [7:0]  sh = '0;
  logic        pscl = 1'b1;
  logic        psda = 1'b1;

  always @(scl, sda, reset) begin
    if (reset === 1'b1) begin
      bitcnt      = 0;
      byte_idx    = 0;
      slv_sda_low = 1'b0;
    end else if (scl === 1'b1 && pscl === 1'b1 && psda === 1'b1 && sda === 1'b0) begin
      starts++;
      bitcnt   = 0;
      byte_idx = 0;
    end else if (scl === 1'b1 && pscl === 1'b1 && psda === 1'b0 && sda === 1'b1) begin
      stops++;
    end else if (pscl !== 1'b1 && scl === 1'b1) begin
      if (bitcnt < 8) sh = {sh[6:0], sda};
      bitcnt++;
      if (bitcnt == 8) rx.push_back(sh);
    end else if (pscl === 1'b1 && scl === 1'b0) begin
      if (bitcnt == 8) begin
        slv_sda_low = (byte_idx != nack_at);
      end else if (bitcnt == 9) begin
        slv_sda_low = 1'b0;
        bitcnt      = 0;
        byte_idx++;
      end
    end
    pscl = scl;
    psda = sda;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input int unsigned base,
                           input logic [47:0] cmd, input int unsigned nbytes);
    logic [7:0] exp_b;
    chk({tag, "_nbytes"}, 64'(rx.size()), 64'(base + nbytes));
    for (int unsigned i = 0; i < nbytes; i++) begin
      exp_b = (i == 0) ? 8'h54 : cmd[47 - 8*(i-1) -: 8];
      chk($sformatf("%s_byte%0d", tag, i), (base + i < rx.size()) ? 64'(rx[base + i]) : 64'hx,
          64'(exp_b));
    end
  endtask

  // Launches one command and counts clks from the accepting edge until done is seen.
  task automatic do_txn(input logic [47:0] cmd, input logic [47:0] cmd2,
                        input int unsigned reissue_at, input int unsigned st_on,
                        input int unsigned st_off, input bit b2b,
                        output int unsigned cycles);
    if (!b2b) begin
      @(posedge clk); #1;
      chk("idle_done_low", done, 1'b0);
      chk("idle_busy_low", busy, 1'b0);
    end
    start   = 1'b1;
    command = cmd;
    @(posedge clk); #1;
    start   = 1'b0;
    command = '0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_nack_clear", nack, 1'b0);
    chk("accept_done_low", done, 1'b0);
    cycles = 0;
    while (done !== 1'b1 && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == reissue_at) begin
        start   = 1'b1;
        command = cmd2;
      end else begin
        start = 1'b0;
      end
      if (cycles == st_on)  slv_scl_low = 1'b1;
      if (cycles == st_off) slv_scl_low = 1'b0;
    end
    start = 1'b0;
    chk("done_busy_low", busy, 1'b0);
  endtask

  int unsigned cyc;
  int unsigned base;
  int unsigned s0;
  int unsigned p0;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    command = '0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nack", nack, 1'b0);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Nominal transaction with an ACKing slave.
    base = rx.size(); s0 = starts; p0 = stops;
    do_txn(48'h0102_0304_0506, '0, 0, 0, 0, 1'b0, cyc);
    chk("t1_cycles", 64'(cyc), 64'd1040);
    chk("t1_nack", nack, 1'b0);
    chk_frame("t1", base, 48'h0102_0304_0506, 7);
    chk("t1_starts", 64'(starts - s0), 64'd1);
    chk("t1_stops", 64'(stops - p0), 64'd1);

    // start raised in the same cycle as done is taken on the following edge.
    base = rx.size();
    do_txn(48'hA5C3_0FF0_8142, '0, 0, 0, 0, 1'b1, cyc);
    chk("t2_cycles", 64'(cyc), 64'd1040);
    chk_frame("t2", base, 48'hA5C3_0FF0_8142, 7);

    // Slave NACKs the third data byte: STOP right after that ACK slot.
    nack_at = 3;
    base = rx.size(); p0 = stops;
    do_txn(48'h1122_3344_5566, '0, 0, 0, 0, 1'b0, cyc);
    chk("t3_cycles", 64'(cyc), 64'd608);
    chk("t3_nack", nack, 1'b1);
    chk_frame("t3", base, 48'h1122_3344_5566, 4);
    chk("t3_stops", 64'(stops - p0), 64'd1);
    nack_at = -1;
    repeat (20) @(posedge clk);
    #1 chk("t3_nack_held", nack, 1'b1);

    // Slave stretches SCL through the second data bit; q2 of that slot starts at clk 184.
    base = rx.size();
    do_txn(48'hFEDC_BA98_7654, '0, 0, 176, 221, 1'b0, cyc);
    chk("t4_cycles", 64'(cyc), 64'd1077);
    chk("t4_nack", nack, 1'b0);
    chk_frame("t4", base, 48'hFEDC_BA98_7654, 7);

    // A second start while busy is dropped.
    base = rx.size(); s0 = starts;
    do_txn(48'h0F1E_2D3C_4B5A, 48'hFFFF_FFFF_FFFF, 100, 0, 0, 1'b0, cyc);
    chk("t5_cycles", 64'(cyc), 64'd1040);
    chk_frame("t5", base, 48'h0F1E_2D3C_4B5A, 7);
    chk("t5_starts", 64'(starts - s0), 64'd1);
    repeat (10) @(posedge clk);
    #1 chk("t5_stay_idle", busy, 1'b0);

    // No slave answers the address.
    nack_at = 0;
    base = rx.size(); s0 = starts; p0 = stops;
    do_txn(48'h0102_0304_0506, '0, 0, 0, 0, 1'b0, cyc);
    chk("t6_cycles", 64'(cyc), 64'd176);
    chk("t6_nack", nack, 1'b1);
    chk_frame("t6", base, 48'h0102_0304_0506, 1);
    chk("t6_starts", 64'(starts - s0), 64'd1);
    chk("t6_stops", 64'(stops - p0), 64'd1);
    nack_at = -1;

    // Reset in the middle of data byte 4 releases the bus between clock edges.
    @(posedge clk); #1;
    start   = 1'b1;
    command = 48'h0102_0304_0506;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (627) @(posedge clk);
    #4 reset = 1'b1;
    #1;
    chk("t7_scl_rel", scl, 1'b1);
    chk("t7_sda_rel", sda, 1'b1);
    chk("t7_busy", busy, 1'b0);
    chk("t7_done", done, 1'b0);
    chk("t7_nack", nack, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    base = rx.size(); s0 = starts;
    do_txn(48'h0102_0304_0506, '0, 0, 0, 0, 1'b0, cyc);
    chk("t7_cycles", 64'(cyc), 64'd1040);
    chk("t7_nack_after", nack, 1'b0);
    chk_frame("t7", base, 48'h0102_0304_0506, 7);
    chk("t7_starts", 64'(starts - s0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_command_master.md
I2C_COMMAND_MASTER -- requirements
Module: i2c_command_master

Interface
REQ-001 SHALL have parameter DIVIDER, default 125: clk cycles per SCL quarter-period; SCL = clk/(4*DIVIDER); legal range 2..1023.
REQ-002 SHALL have parameter SLAVE_ADDR, default 7'h2A: 7-bit address of the display's I2C command receiver.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to transmit one command; sampled each clk.
REQ-006 command  input  48  command word; latched when start is accepted.
REQ-007 busy  output  1  high from start acceptance through STOP completion.
REQ-008 done  output  1  one-clk pulse when a transaction ends, success or failure.
REQ-009 nack  output  1  valid with done: 1 = slave NACKed a byte; held until the next start is accepted.
REQ-010 scl  inout  1  open-drain: driven 0 or released (z); the line value is read back.
REQ-011 sda  inout  1  open-drain: driven 0 or released (z); the line value is read back.

Function
REQ-012 start SHALL be accepted only when busy=0; start while busy=1 is ignored, with no queueing.
REQ-013 On acceptance SHALL latch command, clear nack and set busy in the same cycle.
REQ-014 A quarter-tick counter SHALL count 0..DIVIDER-1 while busy; each wrap advances the bit phase q0..q3.
REQ-015 Frame: START, address byte {SLAVE_ADDR,1'b0}, ACK slot, then 6 data bytes command[47:40] first, each followed by an ACK slot, then STOP.
REQ-016 All bytes SHALL be sent MSB first.
REQ-017 START: SDA released and SCL released for 2 quarters, then SDA low for 2 quarters with SCL high, then SCL low.
REQ-018 Bit timing: q0 SCL low and SDA set; q1 release SCL; q2 SCL high with the value held; q3 drive SCL low.
REQ-019 ACK slot: SDA released during q0; sda sampled at the end of q2; 0 = ACK, 1 = NACK.
REQ-020 Clock stretching: during q2, if the scl readback is 0, the quarter counter SHALL hold until scl reads 1; there is no timeout.
REQ-021 NACK on any byte SHALL abort the remaining bytes, go to STOP, and set nack=1.
REQ-022 STOP: SDA low with SCL low for 1 quarter; release SCL for 1 quarter; release SDA for 2 quarters.
REQ-023 At the end of STOP SHALL raise done for 1 clk, drop busy in the same cycle, and return to IDLE.
REQ-024 States SHALL be IDLE, START, BIT, ACK, STOP; a 3-bit byte counter 0..6 and a 3-bit bit counter 7..0.
REQ-025 Successful transaction length SHALL be exactly 4+63*4+4 = 260 quarters, i.e. 260*DIVIDER clks from acceptance to done with no stretching.
REQ-026 In IDLE both lines SHALL be released.
REQ-027 sda SHALL be driven to 0 only while scl is low, except for the START and STOP edges.
REQ-028 start and done may coincide; the new start SHALL be accepted only in the cycle after done.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, busy=0, done=0, nack=0, scl and sda released, and counters to 0, regardless of clk.
REQ-030 Reset mid-frame SHALL release the bus without a STOP; the next start SHALL begin with a full START.

Verification
REQ-031 DIVIDER=4, ACKing slave model, command=48'h0102_0304_0506 -> bytes 54,01,02,03,04,05,06 seen on bus; done at clk 1040 after acceptance; nack=0.
REQ-032 Slave NACKs the third data byte -> STOP follows that ACK slot, no further bytes sent; done pulse with nack=1.
REQ-033 Slave holds SCL low 37 clks on the second data bit -> frame stretches by exactly 37 clks and the data is unaltered.
REQ-034 start pulsed again while busy with a different command -> ignored; only the first command is transmitted.
REQ-035 Address NACK (no slave present) -> START, 9 bit slots, STOP; done with nack=1 after (4+36+4)*DIVIDER clks.
REQ-036 reset asserted during byte 4 -> scl and sda released within the same clk; busy=0; the following start completes normally.
